// File: rtl/elm_ctrl_pkg.sv
// Shared definitions for the ELM hidden-layer control path.
//   state_t      : sequencer state encoding (also visible on the debug port)
//   P_STEP       : perceptron counter increment per en_P
//   P_PRESET     : value the counter is preset to by rst_P (wraps to 0 on first en_P)
//   P_LAST       : counter value of the last perceptron (raises stop)
//   N_PERCEPTRON : perceptrons per full hidden-layer pass
//   P_CNT_W      : width of the external perceptron counter
package elm_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INIT  = 4'd1,
    ST_ADV   = 4'd2,
    ST_CLR   = 4'd3,
    ST_RUN   = 4'd4,
    ST_DRAIN = 4'd5,
    ST_ACT   = 4'd6,
    ST_WRITE = 4'd7,
    ST_FIN   = 4'd8
  } state_t;

  localparam int P_STEP       = 10;
  localparam int P_PRESET     = 8182;
  localparam int P_LAST       = 5100;
  localparam int N_PERCEPTRON = 511;
  localparam int P_CNT_W      = 13;

endpackage

// File: rtl/elm_hidden_sequencer_if.sv
// Bundle between the hidden-layer sequencer, the host and the datapath.
//   Host      : start (in), busy/done (out)
//   Counter   : rst_P/en_P/done_256 (out), stop (in)
//   Inputs    : in_valid (in), in_idx (out)
//   Datapath  : acc_clr/mac_en/act_en (out)
//   Write     : wr_en (out), wr_ready (in)
//
// Handshake: a hidden-output write transfers on the cycle where
// wr_en && wr_ready. Once raised, wr_en stays high and the sequencer holds
// still until that cycle. An input beat is consumed on every cycle where
// mac_en is high (RUN && in_valid); in_valid low is a stall, never a loss.
interface elm_hidden_sequencer_if #(
  parameter int IDX_W = 8
);
  logic             start;
  logic             busy;
  logic             done;
  logic             rst_P;
  logic             en_P;
  logic             done_256;
  logic             stop;
  logic             in_valid;
  logic [IDX_W-1:0] in_idx;
  logic             acc_clr;
  logic             mac_en;
  logic             act_en;
  logic             wr_en;
  logic             wr_ready;

  // Sequencer side.
  modport master (
    input  start, stop, in_valid, wr_ready,
    output busy, done, rst_P, en_P, done_256, in_idx,
           acc_clr, mac_en, act_en, wr_en
  );

  // Host / counter / datapath side.
  modport slave (
    output start, stop, in_valid, wr_ready,
    input  busy, done, rst_P, en_P, done_256, in_idx,
           acc_clr, mac_en, act_en, wr_en
  );
endinterface

// File: rtl/elm_hidden_sequencer.sv
// Sequencer for one ELM hidden-layer pass.
// For every perceptron: advance the external perceptron counter, clear the
// accumulator, stream N_IN MAC beats (stalling on in_valid), let the MAC
// drain, run the activation unit, then write the result. The pass ends on
// the write handshake of the perceptron for which the counter raised stop.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   io_seq      : elm_hidden_sequencer_if master modport
//   o_dbg_state : current FSM state
module elm_hidden_sequencer
  import elm_ctrl_pkg::*;
#(
  parameter int N_IN    = 256,
  parameter int IDX_W   = 8,
  parameter int MAC_LAT = 3,
  parameter int ACT_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  elm_hidden_sequencer_if.master       io_seq,
  output state_t                       o_dbg_state
);

  localparam int SUB_MAX = (MAC_LAT > ACT_LAT) ? MAC_LAT : ACT_LAT;
  localparam int SUB_W   = $clog2(SUB_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
  // Sub-counter is loaded with (latency-1) and the phase ends when it reads 0.
  localparam logic [SUB_W-1:0] MAC_LOAD = SUB_W'(MAC_LAT - 1);
  localparam logic [SUB_W-1:0] ACT_LOAD = SUB_W'(ACT_LAT - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [SUB_W-1:0] r_sub;
  logic             r_busy;
  logic             r_done;
  logic             r_rst_p;
  logic             r_en_p;
  logic             r_acc_clr;
  logic             r_act_en;
  logic             r_wr_en;

  logic w_beat;
  logic w_last_beat;

  // MAC beat and last-beat flag are combinational so the datapath sees them
  // in the same cycle as the data they qualify.
  assign w_beat      = (r_state == ST_RUN) && io_seq.in_valid;
  assign w_last_beat = w_beat && (r_idx == LAST_IDX);

  // Registered strobes are set on the transition into the state that owns
  // them, so each is high exactly while the FSM sits in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_sub     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rst_p   <= 1'b0;
      r_en_p    <= 1'b0;
      r_acc_clr <= 1'b0;
      r_act_en  <= 1'b0;
      r_wr_en   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_rst_p   <= 1'b0;
      r_en_p    <= 1'b0;
      r_acc_clr <= 1'b0;
      r_act_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_seq.start) begin
            r_state <= ST_INIT;
            r_rst_p <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_INIT: begin
          r_state <= ST_ADV;
          r_en_p  <= 1'b1;
        end
        ST_ADV: begin
          r_state   <= ST_CLR;
          r_acc_clr <= 1'b1;
          r_idx     <= '0;
        end
        ST_CLR: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_last_beat) begin
            r_state <= ST_DRAIN;
            r_idx   <= '0;
            r_sub   <= MAC_LOAD;
          end else if (w_beat) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_sub == '0) begin
            r_state  <= ST_ACT;
            r_sub    <= ACT_LOAD;
            r_act_en <= 1'b1;
          end else begin
            r_sub <= r_sub - 1'b1;
          end
        end
        ST_ACT: begin
          if (r_sub == '0) begin
            r_state <= ST_WRITE;
            r_wr_en <= 1'b1;
          end else begin
            r_sub    <= r_sub - 1'b1;
            r_act_en <= 1'b1;
          end
        end
        ST_WRITE: begin
          // stop was registered by the counter one cycle after done_256,
          // so it is settled by the time any write can complete.
          if (io_seq.wr_ready) begin
            if (io_seq.stop) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_ADV;
              r_en_p  <= 1'b1;
            end
          end else begin
            r_wr_en <= 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_seq.busy     = r_busy;
  assign io_seq.done     = r_done;
  assign io_seq.rst_P    = r_rst_p;
  assign io_seq.en_P     = r_en_p;
  assign io_seq.done_256 = w_last_beat;
  assign io_seq.in_idx   = r_idx;
  assign io_seq.acc_clr  = r_acc_clr;
  assign io_seq.mac_en   = w_beat;
  assign io_seq.act_en   = r_act_en;
  assign io_seq.wr_en    = r_wr_en;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_elm_hidden_sequencer.sv
// Bench for elm_hidden_sequencer (N_IN=4 so full 511-perceptron passes stay short).
// A sequential reference walks the phases of each pass and, per cycle,
// produces both the random input stimulus and the expected output vector.
// An external perceptron-counter model (+10 per en_P, stop at 5100) feeds stop.
module tb_elm_hidden_sequencer;
  import elm_ctrl_pkg::*;

  localparam int TB_N_IN  = 4;
  localparam int TB_IDX_W = 2;
  localparam int TB_MAC   = 3;
  localparam int TB_ACT   = 2;
  localparam int OW       = 9 + TB_IDX_W;
  localparam int PERC_CYC = 1 + 1 + TB_N_IN + TB_MAC + TB_ACT + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elm_hidden_sequencer_if #(.IDX_W(TB_IDX_W)) u_if ();
  state_t dbg_state;

  elm_hidden_sequencer #(
    .N_IN(TB_N_IN), .IDX_W(TB_IDX_W), .MAC_LAT(TB_MAC), .ACT_LAT(TB_ACT)
  ) u_dut (
    .clk(clk), .rst(rst), .io_seq(u_if), .o_dbg_state(dbg_state)
  );

  // ---------------- perceptron counter model ----------------
  logic [P_CNT_W-1:0] p_cnt;
  logic stop_r;
  logic stop_noise;
  always @(posedge clk) begin
    if (rst) begin
      p_cnt  <= '0;
      stop_r <= 1'b0;
    end else begin
      if (u_if.rst_P) begin
        p_cnt  <= P_CNT_W'(P_PRESET);
        stop_r <= 1'b0;
      end else if (u_if.en_P) begin
        p_cnt <= p_cnt + P_CNT_W'(P_STEP);
      end
      if (u_if.done_256) stop_r <= (p_cnt == P_CNT_W'(P_LAST));
    end
  end
  assign u_if.stop = stop_r | stop_noise;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic rs;
    logic st;
    logic v;
    logic r;
    logic sn;
    logic mark;
  } stim_t;

  stim_t          stim_q[$];
  logic [OW-1:0]  exp_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             cyc      = 0;
  int             start_cyc = 0;
  int             done_cyc  = 0;
  int             n_wr = 0, n_d256 = 0, n_done = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] observed();
    return {u_if.busy, u_if.done, u_if.rst_P, u_if.en_P, u_if.done_256,
            u_if.acc_clr, u_if.mac_en, u_if.act_en, u_if.wr_en, u_if.in_idx};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.wr_en && u_if.wr_ready) n_wr++;
      if (u_if.done_256) n_d256++;
      if (u_if.done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit rnd(input int pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

  function automatic logic [OW-1:0] mk(input bit busy, input bit done, input bit rstp,
                                       input bit enp, input bit d256, input bit clr,
                                       input bit mac, input bit act, input bit wr,
                                       input int idx);
    return {busy, done, rstp, enp, d256, clr, mac, act, wr, TB_IDX_W'(idx)};
  endfunction

  task automatic emit(input logic [OW-1:0] e, input bit v, input bit r, input bit st,
                      input bit sn, input bit rs, input bit mark);
    stim_t s;
    s.rs = rs; s.st = st; s.v = v; s.r = r; s.sn = sn; s.mark = mark;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic gen_idle(input int n);
    repeat (n) emit('0, rnd(50), rnd(50), 1'b0, rnd(50), 1'b0, 1'b0);
  endtask

  // One pass from the start cycle to FIN. abort_i >= 0 raises rst on the
  // cycle perceptron abort_i reaches its third beat, and the pass stops there.
  // stall >= 0 forces exactly that many wr_ready-low cycles per write.
  task automatic gen_pass(input int vpct, input int rpct, input int stall,
                          input int abort_i, input int spct);
    int i;
    emit('0, rnd(vpct), rnd(50), 1'b1, rnd(30), 1'b0, 1'b1);
    emit(mk(1,0,1,0,0,0,0,0,0,0), rnd(50), rnd(50), rnd(spct), rnd(30), 1'b0, 1'b0);
    i = 0;
    for (int p = 0; ; p += P_STEP) begin
      int k;
      int w;
      bit r;
      emit(mk(1,0,0,1,0,0,0,0,0,0), rnd(50), rnd(50), rnd(spct), rnd(30), 1'b0, 1'b0);
      emit(mk(1,0,0,0,0,1,0,0,0,0), rnd(50), rnd(50), rnd(spct), rnd(30), 1'b0, 1'b0);
      k = 0;
      while (k < TB_N_IN) begin
        bit v;
        bit ab;
        v  = rnd(vpct);
        ab = (i == abort_i) && (k == 2);
        if (v) emit(mk(1,0,0,0,(k == TB_N_IN-1),0,1,0,0,k), v, rnd(50), rnd(spct), rnd(30), ab, 1'b0);
        else   emit(mk(1,0,0,0,0,0,0,0,0,k), v, rnd(50), rnd(spct), rnd(30), ab, 1'b0);
        if (ab) return;
        if (v) k++;
      end
      repeat (TB_MAC) emit(mk(1,0,0,0,0,0,0,0,0,0), rnd(50), rnd(50), rnd(spct), rnd(30), 1'b0, 1'b0);
      repeat (TB_ACT) emit(mk(1,0,0,0,0,0,0,1,0,0), rnd(50), rnd(50), rnd(spct), rnd(30), 1'b0, 1'b0);
      w = 0;
      do begin
        r = (stall >= 0) ? (w >= stall) : rnd(rpct);
        emit(mk(1,0,0,0,0,0,0,0,1,0), rnd(50), r, rnd(spct), 1'b0, 1'b0, 1'b0);
        w++;
      end while (!r);
      i++;
      if (p == P_LAST) break;
    end
    emit(mk(0,1,0,0,0,0,0,0,0,0), rnd(50), rnd(50), rnd(spct), rnd(30), 1'b0, 1'b0);
  endtask

  // ---------------- driver ----------------
  task automatic run_queue();
    stim_t s;
    logic [OW-1:0] e;
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      cyc++;
      s = stim_q.pop_front();
      rst           = s.rs;
      u_if.start    = s.st;
      u_if.in_valid = s.v;
      u_if.wr_ready = s.r;
      stop_noise    = s.sn;
      if (s.mark) start_cyc = cyc;
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("cyc%0d_outputs", cyc), 64'(observed()), 64'(e));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int wr0, d0, dn0;
    u_if.start    = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.wr_ready = 1'b0;
    stop_noise    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'(observed()), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));

    // Full pass, no stalls: exact latency and per-pass counts.
    gen_idle(3);
    run_queue();
    wr0 = n_wr; d0 = n_d256; dn0 = n_done;
    gen_pass(100, 100, -1, -1, 0);
    gen_idle(2);
    run_queue();
    check("pass_latency", 64'(done_cyc - start_cyc), 64'(2 + N_PERCEPTRON * PERC_CYC));
    check("wr_handshakes", 64'(n_wr - wr0), 64'(N_PERCEPTRON));
    check("done256_pulses", 64'(n_d256 - d0), 64'(N_PERCEPTRON));
    check("done_pulses", 64'(n_done - dn0), 64'd1);
    check("busy_after", 64'(u_if.busy), 64'd0);

    // Fixed 5-cycle write stall, then a back-to-back pass started right after FIN.
    gen_pass(60, 100, 5, -1, 20);
    gen_pass(50, 50, -1, -1, 20);
    gen_idle(2);
    run_queue();

    // Reset mid-RUN: no done for the aborted pass.
    dn0 = n_done;
    gen_pass(70, 60, -1, 3, 20);
    gen_idle(4);
    run_queue();
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    check("abort_no_done", 64'(n_done - dn0), 64'd0);

    // Clean restart after the abort.
    wr0 = n_wr; dn0 = n_done;
    gen_pass(80, 70, -1, -1, 20);
    gen_idle(3);
    run_queue();
    check("restart_wr", 64'(n_wr - wr0), 64'(N_PERCEPTRON));
    check("restart_done", 64'(n_done - dn0), 64'd1);
    check("restart_state", 64'(dbg_state), 64'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elm_hidden_sequencer.md
Name: elm_hidden_sequencer

Overview:
Top-level sequencer for the ELM hidden-layer pass. It drives the perceptron index counter (en_P, rst_P, done_256, with stop returned) and steps the 256-input MAC loop for each perceptron. It also issues accumulator-clear, MAC-enable, activation and result-write strobes. It sits between the host start/done handshake and the hidden-layer datapath (input/weight memories, MAC, activation unit, hidden-output RAM).

Parameters:
N_IN, 256, inputs per perceptron (MAC beats per perceptron)
IDX_W, 8, width of in_idx (clog2(N_IN))
MAC_LAT, 3, MAC pipeline drain cycles after the last beat
ACT_LAT, 2, activation unit latency in cycles

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  begin full hidden-layer pass (sampled in IDLE only)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at end of pass
rst_P  output  1  preset perceptron counter (to 8182)
en_P  output  1  advance perceptron counter by 10
done_256  output  1  one-cycle pulse on the last MAC beat of a perceptron
stop  input  1  registered last-perceptron flag from the counter (index 5100 seen at done_256)
in_valid  input  1  input/weight data valid for current in_idx
in_idx  output  IDX_W  input/weight read address within a perceptron
acc_clr  output  1  clear MAC accumulator
mac_en  output  1  accumulate this cycle (= RUN & in_valid)
act_en  output  1  activation unit enable
wr_en  output  1  hidden-output write request
wr_ready  input  1  hidden-output RAM accepts write

Behaviour:
- Reset: state=IDLE. All outputs 0, in_idx=0. Reset mid-pass aborts immediately, with no done pulse.
- States: IDLE, INIT, ADV, CLR, RUN, DRAIN, ACT, WRITE, FIN. Single registered state with a registered sub-counter.
- IDLE: when start=1, go to INIT. start is ignored in all other states.
- INIT (1 cycle): rst_P=1, busy=1. Next state is ADV.
- ADV (1 cycle): en_P=1, so the counter goes 8182→0 on the first perceptron and +10 thereafter. Next state is CLR.
- CLR (1 cycle): acc_clr=1, in_idx=0. Next state is RUN.
- RUN:
  - mac_en=in_valid.
  - in_idx increments only on beats where in_valid=1.
  - A beat with in_valid=1 and in_idx=N_IN-1 asserts done_256 combinationally in that same cycle, then the FSM goes to DRAIN and in_idx returns to 0.
  - in_valid low stalls without limit; no beats are lost or duplicated.
- DRAIN: MAC_LAT cycles with all strobes low. Next state is ACT.
- ACT: act_en=1 for ACT_LAT cycles. Next state is WRITE.
- WRITE:
  - wr_en=1 and held until wr_ready=1.
  - On the handshake cycle: if stop=1, go to FIN; otherwise go to ADV.
  - stop is valid here because the counter registered it one cycle after done_256.
- FIN (1 cycle): done=1. busy falls in the same cycle. Next state is IDLE.
- Sub-counter is shared by DRAIN and ACT; it is loaded on entry and counts down to 0.
- Strobe exclusivity: at most one of rst_P, en_P, acc_clr, mac_en, act_en, wr_en is high in any cycle.
- Per-perceptron latency with in_valid and wr_ready tied high: 1+1+N_IN+MAC_LAT+ACT_LAT+1 = 264 cycles at defaults.
- Full pass: 511 perceptrons (index 0..5100 step 10), so 2 + 511×264 = 134,906 cycles from start to done.
- stop=1 arriving outside WRITE has no effect until WRITE.

Decomposition:
- Shared package elm_ctrl_pkg holds:
  - state enum encoding;
  - constants P_STEP=10, P_PRESET=8182, P_LAST=5100, N_PERCEPTRON=511.
- No sub-module. The FSM and the in_idx/sub-counter live in one module. The perceptron counter stays external.

Test Plan:
1. Reset then start=1 with N_IN=4, MAC_LAT=3, ACT_LAT=2, stop model tied 0 → rst_P at cycle 1, en_P at cycle 2, acc_clr at cycle 3, mac_en at cycles 4–7 with in_idx 0,1,2,3, done_256 at cycle 7, act_en at cycles 11–12, wr_en at cycle 13, en_P again at cycle 14.
2. Full default pass with a behavioural counter model (+10, stop at 5100) → exactly 511 wr_en handshakes, 511 done_256 pulses, done at cycle 134,906, busy low afterward.
3. in_valid pattern 1,0,0,1 during RUN with N_IN=4 → in_idx holds during the gaps, exactly 4 mac_en beats, done_256 only on the 4th valid beat.
4. wr_ready low for 5 cycles in WRITE → wr_en held for 6 cycles, no state advance, en_P follows one cycle after the handshake.
5. rst asserted in cycle 100 of RUN → next cycle state=IDLE and all outputs 0. A later start begins cleanly with rst_P, and done is never pulsed for the aborted pass.
6. start pulsed during RUN and during FIN → ignored. A start one cycle after done → new pass begins with rst_P.
